sseg_disp_mux: RTL

- Time-multiplexed driver for a common-anode multi-digit seven-segment display.
- Consumes the 8-bit per-digit segment patterns produced by the hex/sign decoders (bit 7 = dp, bits 6:0 = g..a) and drives the shared segment bus and active-low digit anodes.
- Loads are double-buffered and applied only at frame boundaries, so the display never tears.
- Sits between the arithmetic/decoder test blocks and the board display pins.

---
 rtl/sseg_disp_mux.sv | 119 +++++++++++
 1 files changed

// File: rtl/sseg_disp_mux.sv
// Purpose : time-multiplexed common-anode 7-segment driver with frame-synchronous double buffering.
// Latency : an/sseg are registered one cycle behind the scan counter; a load becomes visible the frame after the next boundary.
// Backpressure: none; load is a fire-and-forget strobe, the last load before a frame boundary wins.
//
// Ports:
//   clk        - system clock
//   reset      - synchronous, active-high reset
//   load       - one-cycle strobe, captures din into the pending buffer
//   din        - N_DIG packed 8-bit patterns, digit k = din[8k+7:8k], digit 0 rightmost
//                (bit 7 = dp, bits 6:0 = g..a, active-low segments passed through as-is)
//   blank_mask - bit k = 1 keeps digit k dark; sampled live
//   bright     - 4-bit duty control, only present when SSEG_DISP_MUX_DIM_EN is defined
//   pend       - pending buffer holds data not yet transferred to the display
//   frame_done - one-cycle pulse after each frame wrap
//   an         - active-low digit enables, at most one low
//   sseg       - segment pattern of the enabled digit, 8'hFF when all digits are dark
//
// Optional feature macro: SSEG_DISP_MUX_DIM_EN (adds the bright input and PWM dimming).

module sseg_disp_mux #(
  parameter int N_DIG     = 4,
  parameter int SLOT_BITS = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [8*N_DIG-1:0] din,
  input  logic [N_DIG-1:0]   blank_mask,
`ifdef SSEG_DISP_MUX_DIM_EN
  input  logic [3:0]         bright,
`endif
  output logic               pend,
  output logic               frame_done,
  output logic [N_DIG-1:0]   an,
  output logic [7:0]         sseg
);

  localparam int                   DIG_W    = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam logic [SLOT_BITS-1:0] SLOT_MAX = '1;
  localparam logic [DIG_W-1:0]     DIG_LAST = DIG_W'(N_DIG - 1);

  // scan position
  logic [SLOT_BITS-1:0] slot_cnt;
  logic [DIG_W-1:0]     dig;

  // double buffer: pnd_buf collects loads, act_buf is what is being scanned out
  logic [N_DIG-1:0][7:0] act_buf;
  logic [N_DIG-1:0][7:0] pnd_buf;

  logic                 slot_end;
  logic                 boundary;
  logic                 dim_on;
  logic [N_DIG-1:0]     an_nxt;
  logic [7:0]           sseg_nxt;

  always_comb begin
    slot_end = (slot_cnt == SLOT_MAX);
    boundary = slot_end && (dig == DIG_LAST);
  end

`ifdef SSEG_DISP_MUX_DIM_EN
  // PWM over each slot: the top four slot bits form a 16-step phase that
  // is compared against bright, so bright = 0 is dark and 15 gives 15/16.
  always_comb begin
    dim_on = (slot_cnt[SLOT_BITS-1 -: 4] < bright);
  end
`else
  always_comb begin
    dim_on = 1'b1;
  end
`endif

  // Slot position 0 is always dark so the previous digit's anode is fully
  // off before the next one turns on (anti-ghosting dead time).
  always_comb begin
    an_nxt = '1;
    if ((slot_cnt != '0) && !blank_mask[dig] && dim_on) begin
      an_nxt[dig] = 1'b0;
    end
    sseg_nxt = (&an_nxt) ? 8'hFF : act_buf[dig];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_cnt   <= '0;
      dig        <= '0;
      act_buf    <= '1;
      pnd_buf    <= '1;
      pend       <= 1'b0;
      frame_done <= 1'b0;
      an         <= '1;
      sseg       <= 8'hFF;
    end else begin
      slot_cnt <= slot_cnt + SLOT_BITS'(1);
      if (slot_end) begin
        dig <= (dig == DIG_LAST) ? '0 : dig + DIG_W'(1);
      end

      frame_done <= boundary;

      // Transfer uses the pending contents from before this edge, so a load
      // landing on the boundary cycle is queued for the following frame.
      if (boundary && pend) begin
        act_buf <= pnd_buf;
      end

      if (load) begin
        pnd_buf <= din;
        pend    <= 1'b1;
      end else if (boundary) begin
        pend    <= 1'b0;
      end

      an   <= an_nxt;
      sseg <= sseg_nxt;
    end
  end

endmodule
